mux_sync: RTL and testbench

MUX_SYNC -- requirements
Module: mux_sync

---
 rtl/mux_sync.sv | 131 +++++++++++++
 tb/tb_mux_sync.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mux_sync.sv
// mux_sync: registered N:1 channel mux with sequenced tri-state output enable
// and a saturating count of output bit transitions.
module mux_sync #(
  parameter int WIDTH   = 4,
  parameter int NCH     = 2,
  parameter int SELW    = 1,
  parameter int EN_DLY  = 2,
  parameter int DIS_DLY = 2,
  parameter int CNTW    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [SELW-1:0]      s,
  input  logic [NCH*WIDTH-1:0] a,
  input  logic                 notoe,
  input  logic                 cnt_clr,
  output logic [WIDTH-1:0]     y,
  output logic                 y_valid,
  output logic                 sel_err,
  output logic [CNTW-1:0]      toggle_cnt
);

  typedef enum logic [1:0] {
    DISABLED,
    ENABLING,
    ACTIVE,
    DISABLING
  } state_t;

  localparam int DMAX = (EN_DLY > DIS_DLY) ? EN_DLY : DIS_DLY;
  localparam int DW   = (DMAX > 1) ? $clog2(DMAX) : 1;
  localparam int FW   = $clog2(WIDTH + 1);
  localparam int SW   = CNTW + 1;

  state_t state, state_nx;

  logic [DW-1:0]    dcnt, dcnt_nx;
  logic [WIDTH-1:0] dreg, dreg_nx;
  logic [WIDTH-1:0] sel_data, diff;
  logic [FW-1:0]    flips;
  logic [SW-1:0]    sum;
  logic [CNTW-1:0]  cnt_nx;
  logic             sel_ok, load, err_nx;

  always_comb begin
    sel_data = '0;
    sel_ok   = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (s == SELW'(k)) begin
        sel_data = a[k*WIDTH +: WIDTH];
        sel_ok   = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    load     = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      DISABLED: begin
        if (!notoe) begin
          state_nx = ENABLING;
          dcnt_nx  = DW'(EN_DLY - 1);
        end
      end
      ENABLING: begin
        if (notoe) begin
          state_nx = DISABLED;
          dcnt_nx  = '0;
        end else if (dcnt != '0) begin
          dcnt_nx = dcnt - DW'(1);
        end else begin
          state_nx = ACTIVE;
          load     = sel_ok;
        end
      end
      ACTIVE: begin
        if (notoe) begin
          state_nx = DISABLING;
          dcnt_nx  = DW'(DIS_DLY - 1);
        end else if (sel_ok) begin
          load = 1'b1;
        end else begin
          err_nx = 1'b1;
        end
      end
      DISABLING: begin
        if (dcnt != '0) begin
          dcnt_nx = dcnt - DW'(1);
        end else begin
          state_nx = DISABLED;
        end
      end
      default: state_nx = DISABLED;
    endcase
  end

  // Toggle accounting only ever sees dreg, so z<->driven edges never count.
  always_comb begin
    dreg_nx = load ? sel_data : dreg;
    diff    = dreg ^ dreg_nx;
    flips   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      flips = flips + FW'(diff[i]);
    end
    sum    = {1'b0, toggle_cnt} + SW'(flips);
    cnt_nx = sum[CNTW] ? '1 : sum[CNTW-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= DISABLED;
      dcnt       <= '0;
      dreg       <= '0;
      sel_err    <= 1'b0;
      toggle_cnt <= '0;
    end else begin
      state      <= state_nx;
      dcnt       <= dcnt_nx;
      dreg       <= dreg_nx;
      sel_err    <= err_nx;
      toggle_cnt <= cnt_clr ? '0 : cnt_nx;
    end
  end

  assign y_valid = (state == ACTIVE);
  assign y = (state == ACTIVE || state == DISABLING) ? dreg : {WIDTH{1'bz}};

endmodule

// File: tb/tb_mux_sync.sv
// tb_mux_sync: scoreboard bench for mux_sync, default build plus a
// 3-channel build with a 4-bit saturating toggle counter.
module tb_mux_sync;

  // Outputs land on pulled-up nets: a released bus reads all ones.
  localparam logic [3:0] ZP = 4'hF;

  typedef struct {
    string       tag;
    logic [3:0]  y;
    logic        v;
    logic [15:0] c;
    logic        e;
  } exp_t;

  exp_t sb[$];
  int   nvec;
  int   nerr;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        r0, n0, c0;
  logic        s0;
  logic [7:0]  a0;
  tri1  [3:0]  y0;
  logic        v0, e0;
  logic [15:0] t0;

  logic        r1, n1, c1;
  logic [1:0]  s1;
  logic [11:0] a1;
  tri1  [3:0]  y1;
  logic        v1, e1;
  logic [3:0]  t1;

  mux_sync u0 (
    .clk(clk), .reset(r0), .s(s0), .a(a0), .notoe(n0),
    .cnt_clr(c0), .y(y0), .y_valid(v0), .sel_err(e0),
    .toggle_cnt(t0)
  );

  mux_sync #(
    .WIDTH(4), .NCH(3), .SELW(2),
    .EN_DLY(2), .DIS_DLY(2), .CNTW(4)
  ) u1 (
    .clk(clk), .reset(r1), .s(s1), .a(a1), .notoe(n1),
    .cnt_clr(c1), .y(y1), .y_valid(v1), .sel_err(e1),
    .toggle_cnt(t1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] ey,
                      input logic ev, input int ec, input logic ee);
    exp_t x;
    x.tag = tag;
    x.y   = ey;
    x.v   = ev;
    x.c   = 16'(ec);
    x.e   = ee;
    sb.push_back(x);
  endtask

  task automatic pop_cmp(input logic [3:0] gy, input logic gv,
                         input logic [15:0] gc, input logic ge);
    exp_t x;
    if (sb.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL sb_empty: got 0 entries expected 1");
      return;
    end
    x = sb.pop_front();
    chk({x.tag, ".y"}, 32'(gy), 32'(x.y));
    chk({x.tag, ".v"}, 32'(gv), 32'(x.v));
    chk({x.tag, ".cnt"}, 32'(gc), 32'(x.c));
    chk({x.tag, ".err"}, 32'(ge), 32'(x.e));
  endtask

  task automatic step0(input logic r, input logic n, input logic s,
                       input logic c, input string tag,
                       input logic [3:0] ey, input logic ev,
                       input int ec, input logic ee);
    r0 = r;
    n0 = n;
    s0 = s;
    c0 = c;
    push(tag, ey, ev, ec, ee);
    @(posedge clk);
    #1;
    pop_cmp(y0, v0, t0, e0);
  endtask

  task automatic step1(input logic r, input logic n, input logic [1:0] s,
                       input logic c, input string tag,
                       input logic [3:0] ey, input logic ev,
                       input int ec, input logic ee);
    r1 = r;
    n1 = n;
    s1 = s;
    c1 = c;
    push(tag, ey, ev, ec, ee);
    @(posedge clk);
    #1;
    pop_cmp(y1, v1, 16'(t1), e1);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    r0 = 1'b1; n0 = 1'b1; s0 = 1'b0; c0 = 1'b0; a0 = 8'hA5;
    r1 = 1'b1; n1 = 1'b1; s1 = 2'd0; c1 = 1'b0; a1 = 12'h0F0;

    step0(1, 1, 0, 0, "rst0a", ZP, 0, 0, 0);
    step0(1, 1, 0, 0, "rst0b", ZP, 0, 0, 0);
    step0(0, 0, 0, 0, "en_e0", ZP, 0, 0, 0);
    step0(0, 0, 0, 0, "en_e1", ZP, 0, 0, 0);
    step0(0, 0, 0, 0, "en_e2", 4'h5, 1, 2, 0);
    step0(0, 0, 1, 0, "sel1", 4'hA, 1, 6, 0);
    step0(0, 0, 0, 0, "sel0", 4'h5, 1, 10, 0);
    step0(0, 0, 1, 0, "sel1b", 4'hA, 1, 14, 0);
    step0(0, 1, 1, 0, "dis_d0", 4'hA, 0, 14, 0);
    step0(0, 0, 1, 0, "dis_d1", 4'hA, 0, 14, 0);
    step0(0, 1, 1, 0, "dis_d2", ZP, 0, 14, 0);
    step0(0, 0, 1, 0, "ab_e0", ZP, 0, 14, 0);
    step0(0, 1, 1, 0, "ab_off", ZP, 0, 14, 0);
    step0(0, 0, 1, 0, "re_e0", ZP, 0, 14, 0);
    step0(0, 0, 1, 0, "re_e1", ZP, 0, 14, 0);
    step0(0, 0, 1, 0, "re_e2", 4'hA, 1, 14, 0);
    step0(0, 0, 0, 1, "clr_tg", 4'h5, 1, 0, 0);
    step0(0, 0, 1, 0, "post_clr", 4'hA, 1, 4, 0);
    step0(0, 1, 1, 0, "d2_d0", 4'hA, 0, 4, 0);
    step0(0, 1, 1, 0, "d2_d1", 4'hA, 0, 4, 0);
    step0(0, 1, 1, 0, "d2_d2", ZP, 0, 4, 0);
    step0(0, 0, 1, 0, "en3_e0", ZP, 0, 4, 0);
    step0(1, 0, 1, 0, "rst_enab", ZP, 0, 0, 0);
    step0(0, 0, 1, 0, "en4_e0", ZP, 0, 0, 0);
    step0(0, 0, 1, 0, "en4_e1", ZP, 0, 0, 0);
    step0(0, 0, 1, 0, "en4_e2", 4'hA, 1, 2, 0);
    step0(0, 1, 1, 0, "d3_d0", 4'hA, 0, 2, 0);
    step0(1, 1, 1, 0, "rst_disab", ZP, 0, 0, 0);

    step1(1, 1, 0, 0, "b_rst", ZP, 0, 0, 0);
    step1(0, 0, 0, 0, "b_e0", ZP, 0, 0, 0);
    step1(0, 0, 0, 0, "b_e1", ZP, 0, 0, 0);
    step1(0, 0, 0, 0, "b_e2", 4'h0, 1, 0, 0);
    step1(0, 0, 1, 0, "b_s1", 4'hF, 1, 4, 0);
    step1(0, 0, 0, 0, "b_s0", 4'h0, 1, 8, 0);
    step1(0, 0, 1, 0, "b_s1b", 4'hF, 1, 12, 0);
    step1(0, 0, 3, 0, "b_oor", 4'hF, 1, 12, 1);
    step1(0, 0, 0, 0, "b_sat", 4'h0, 1, 15, 0);
    step1(0, 0, 1, 0, "b_sat2", 4'hF, 1, 15, 0);
    step1(0, 0, 2, 0, "b_ch2", 4'h0, 1, 15, 0);
    step1(0, 0, 1, 1, "b_clr", 4'hF, 1, 0, 0);

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
